// File: rtl/gb_bus_master.sv
// GameBoy cartridge bus initiator: expands host requests into timed T1..T4 bus cycles,
// with an MBC5 bank-register cache for banked reads of the 0x4000-0x7FFF window.
module gb_bus_master #(
  parameter int unsigned PHASE_CLKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic [8:0]  req_bank,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_doe,
  input  logic [7:0]  bus_din,
  output logic        bus_phi,
  output logic        bus_rd_n,
  output logic        bus_wr_n,
  output logic        bus_cs_n
);

  localparam int unsigned CW = (PHASE_CLKS > 1) ? $clog2(PHASE_CLKS) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_T3   = 3'd3;
  localparam logic [2:0] S_T4   = 3'd4;

  localparam logic [1:0] OP_READ   = 2'd0;
  localparam logic [1:0] OP_WRITE  = 2'd1;
  localparam logic [1:0] OP_BANKED = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  // idx 0/1 are the bank-register writes of a miss; idx 2 is always the final cycle
  localparam logic [1:0] IDX_LAST = 2'd2;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    op_q, op_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [8:0]    bank_q, bank_d;
  logic          bank_valid;
  logic [8:0]    bank_cache;

  logic          done_c, rsvd_c, cache_set_c, cache_clr_c;
  logic          cyc_wr_c;
  logic [15:0]   cyc_addr_c;
  logic [7:0]    cyc_data_c;
  logic          in_t24_c, active_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= IDX_LAST;
      op_q    <= OP_READ;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      bank_q  <= 9'h000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bank_q  <= bank_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    bank_d      = bank_q;
    done_c      = 1'b0;
    rsvd_c      = 1'b0;
    cache_set_c = 1'b0;
    cache_clr_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          bank_d  = req_bank;
          cnt_d   = '0;
          if (req_op == OP_RSVD) begin
            rsvd_c = 1'b1;
          end else begin
            state_d = S_T1;
            idx_d   = (req_op == OP_BANKED && !(bank_valid && bank_cache == req_bank))
                      ? 2'd0 : IDX_LAST;
          end
        end
      end
      default: begin
        if (cnt_q == CW'(PHASE_CLKS - 1)) begin
          cnt_d = '0;
          if (state_q == S_T4) begin
            if (idx_q == IDX_LAST) begin
              state_d     = S_IDLE;
              done_c      = 1'b1;
              cache_clr_c = (op_q == OP_WRITE) && (addr_q[15:13] == 3'b001);
            end else begin
              state_d     = S_T1;
              idx_d       = 2'(idx_q + 2'd1);
              cache_set_c = (idx_q == 2'd1);
            end
          end else begin
            state_d = 3'(state_q + 3'd1);
          end
        end else begin
          cnt_d = CW'(cnt_q + CW'(1));
        end
      end
    endcase
  end

  // Descriptor of the bus cycle the next state belongs to
  always_comb begin
    cyc_wr_c   = 1'b0;
    cyc_addr_c = addr_d;
    cyc_data_c = wdata_d;
    case (op_d)
      OP_WRITE: cyc_wr_c = 1'b1;
      OP_BANKED: begin
        case (idx_d)
          2'd0: begin
            cyc_wr_c   = 1'b1;
            cyc_addr_c = 16'h2000;
            cyc_data_c = bank_d[7:0];
          end
          2'd1: begin
            cyc_wr_c   = 1'b1;
            cyc_addr_c = 16'h3000;
            cyc_data_c = {7'b0, bank_d[8]};
          end
          default: cyc_addr_c = {2'b01, addr_d[13:0]};
        endcase
      end
      default: ;
    endcase
  end

  assign active_c = (state_d != S_IDLE);
  assign in_t24_c = (state_d == S_T2) || (state_d == S_T3) || (state_d == S_T4);

  // Registered pad strobes and response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'hFF;
      bus_addr  <= 16'h0000;
      bus_dout  <= 8'h00;
      bus_doe   <= 1'b0;
      bus_phi   <= 1'b0;
      bus_rd_n  <= 1'b1;
      bus_wr_n  <= 1'b1;
      bus_cs_n  <= 1'b1;
    end else begin
      req_ready <= !active_c;
      rsp_valid <= done_c || rsvd_c;
      if (rsvd_c) begin
        rsp_rdata <= 8'hFF;
      end else if (done_c) begin
        rsp_rdata <= (op_q == OP_WRITE) ? 8'hFF : bus_din;
      end
      if (state_d == S_T1) begin
        bus_addr <= cyc_addr_c;
      end
      if (cyc_wr_c && in_t24_c) begin
        bus_dout <= cyc_data_c;
      end
      bus_doe  <= cyc_wr_c && in_t24_c;
      bus_phi  <= (state_d == S_T3) || (state_d == S_T4);
      bus_rd_n <= !(active_c && !cyc_wr_c);
      bus_wr_n <= !(cyc_wr_c && state_d == S_T3);
      bus_cs_n <= !(in_t24_c && cyc_addr_c[15:13] == 3'b101);
    end
  end

  // Bank cache follows completed bank-register programming and plain MBC writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_valid <= 1'b0;
      bank_cache <= 9'h000;
    end else begin
      if (cache_set_c) begin
        bank_valid <= 1'b1;
        bank_cache <= bank_q;
      end else if (cache_clr_c) begin
        bank_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gb_bus_master.sv
// Randomized self-checking bench for gb_bus_master against a per-request bus-cycle model.
module tb_gb_bus_master;
  localparam int unsigned P   = 2;
  localparam int unsigned CYC = 4 * P;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic [8:0]  req_bank;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_doe;
  logic [7:0]  bus_din;
  logic        bus_phi;
  logic        bus_rd_n;
  logic        bus_wr_n;
  logic        bus_cs_n;

  gb_bus_master #(.PHASE_CLKS(P)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_bank(req_bank),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_doe(bus_doe), .bus_din(bus_din),
    .bus_phi(bus_phi), .bus_rd_n(bus_rd_n), .bus_wr_n(bus_wr_n), .bus_cs_n(bus_cs_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: cartridge bank register as the bench believes it is programmed
  bit          m_bank_valid = 1'b0;
  logic [8:0]  m_bank_cache = 9'h000;
  logic [15:0] m_last_addr  = 16'h0000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [30:0] mk(input logic rdy, input logic vld, input logic [15:0] a,
                                     input logic rd, input logic wr, input logic cs,
                                     input logic phi, input logic doe, input logic [7:0] d);
    return {rdy, vld, a, rd, wr, cs, phi, doe, d};
  endfunction

  function automatic logic [30:0] obs(input logic show_dout);
    return {req_ready, rsp_valid, bus_addr, bus_rd_n, bus_wr_n, bus_cs_n, bus_phi, bus_doe,
            show_dout ? bus_dout : 8'h00};
  endfunction

  // Issue one request at the current negedge and check every clock until completion.
  task automatic do_req(input logic [1:0] op, input logic [15:0] addr, input logic [7:0] wd,
                        input logic [8:0] bank, input bit hold, input int abort_at);
    logic        c_wr[3];
    logic [15:0] c_addr[3];
    logic [7:0]  c_data[3];
    int          n;
    bit          miss;
    logic [7:0]  din_last;
    logic [30:0] e;
    int          c, ph;
    logic        e_doe;
    n = 0;
    miss = 1'b0;
    din_last = 8'h00;
    case (op)
      2'd0: begin c_wr[0] = 1'b0; c_addr[0] = addr; c_data[0] = 8'h00; n = 1; end
      2'd1: begin c_wr[0] = 1'b1; c_addr[0] = addr; c_data[0] = wd; n = 1; end
      2'd2: begin
        miss = !(m_bank_valid && m_bank_cache == bank);
        if (miss) begin
          c_wr[0] = 1'b1; c_addr[0] = 16'h2000; c_data[0] = bank[7:0];
          c_wr[1] = 1'b1; c_addr[1] = 16'h3000; c_data[1] = {7'b0, bank[8]};
          n = 2;
        end
        c_wr[n] = 1'b0; c_addr[n] = 16'h4000 | {2'b00, addr[13:0]}; c_data[n] = 8'h00;
        n = n + 1;
      end
      default: n = 0;
    endcase

    check("ready_pre", 64'(req_ready), 64'(1'b1));
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_bank = bank;
    @(posedge clk);
    @(negedge clk);
    if (!hold) begin
      req_valid = 1'b0;
      req_op = 2'($urandom); req_addr = 16'($urandom);
      req_wdata = 8'($urandom); req_bank = 9'($urandom);
    end

    if (n == 0) begin
      check("rsvd", 64'(obs(1'b0)), 64'(mk(1, 1, m_last_addr, 1, 1, 1, 0, 0, 8'h00)));
      check("rsvd_rdata", 64'(rsp_rdata), 64'(8'hFF));
      return;
    end

    for (int i = 0; i < n * int'(CYC); i++) begin
      if (i > 0) @(negedge clk);
      c = i / int'(CYC);
      ph = (i / int'(P)) % 4;
      e_doe = c_wr[c] && ph >= 1;
      e = mk(0, 0, c_addr[c], c_wr[c], !(c_wr[c] && ph == 2),
             !(ph >= 1 && c_addr[c][15:13] == 3'b101), ph >= 2, e_doe,
             e_doe ? c_data[c] : 8'h00);
      check("bus", 64'(obs(e_doe)), 64'(e));
      if (i == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort", 64'(obs(1'b1)), 64'(mk(1, 0, 16'h0000, 1, 1, 1, 0, 0, 8'h00)));
        check("abort_rdata", 64'(rsp_rdata), 64'(8'hFF));
        m_bank_valid = 1'b0;
        m_last_addr = 16'h0000;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_quiet", 64'(obs(1'b0)), 64'(mk(1, 0, 16'h0000, 1, 1, 1, 0, 0, 8'h00)));
        return;
      end
      bus_din = 8'($urandom);
      din_last = bus_din;
    end

    @(negedge clk);
    m_last_addr = c_addr[n-1];
    check("done", 64'(obs(1'b0)), 64'(mk(1, 1, m_last_addr, 1, 1, 1, 0, 0, 8'h00)));
    check("rdata", 64'(rsp_rdata), 64'(c_wr[n-1] ? 8'hFF : din_last));
    if (op == 2'd2 && miss) begin
      m_bank_valid = 1'b1;
      m_bank_cache = bank;
    end
    if (op == 2'd1 && addr >= 16'h2000 && addr < 16'h4000) m_bank_valid = 1'b0;
  endtask

  task automatic idle_reset();
    rst = 1'b1;
    #1;
    check("rst_idle", 64'(obs(1'b1)), 64'(mk(1, 0, 16'h0000, 1, 1, 1, 0, 0, 8'h00)));
    check("rst_rdata", 64'(rsp_rdata), 64'(8'hFF));
    m_bank_valid = 1'b0;
    m_last_addr = 16'h0000;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release", 64'(obs(1'b0)), 64'(mk(1, 0, 16'h0000, 1, 1, 1, 0, 0, 8'h00)));
  endtask

  initial begin
    logic [8:0]  banks[3];
    logic [15:0] a;
    banks[0] = 9'h1A3; banks[1] = 9'h005; banks[2] = 9'h100;
    rst = 1'b1;
    req_valid = 1'b0; req_op = 2'd0; req_addr = 16'h0000; req_wdata = 8'h00;
    req_bank = 9'h000; bus_din = 8'h00;
    repeat (2) @(negedge clk);
    check("reset", 64'(obs(1'b1)), 64'(mk(1, 0, 16'h0000, 1, 1, 1, 0, 0, 8'h00)));
    check("reset_rdata", 64'(rsp_rdata), 64'(8'hFF));
    rst = 1'b0;
    @(negedge clk);
    idle_reset();

    do_req(2'd0, 16'h0150, 8'h00, 9'h000, 1'b0, -1);
    do_req(2'd1, 16'hA000, 8'h5A, 9'h000, 1'b0, -1);
    do_req(2'd0, 16'hA123, 8'h00, 9'h000, 1'b0, -1);
    do_req(2'd2, 16'h0010, 8'h00, 9'h1A3, 1'b0, -1);
    do_req(2'd2, 16'h0010, 8'h00, 9'h1A3, 1'b0, -1);
    do_req(2'd1, 16'h2100, 8'h07, 9'h000, 1'b0, -1);
    do_req(2'd2, 16'h0010, 8'h00, 9'h1A3, 1'b0, -1);
    do_req(2'd1, 16'h4000, 8'h11, 9'h000, 1'b0, -1);
    do_req(2'd2, 16'h3FFF, 8'h00, 9'h1A3, 1'b0, -1);
    do_req(2'd1, 16'h3FFF, 8'h00, 9'h000, 1'b0, -1);
    do_req(2'd2, 16'h0010, 8'h00, 9'h1A3, 1'b0, int'(CYC + 2 * P));
    do_req(2'd2, 16'h0010, 8'h00, 9'h1A3, 1'b0, -1);
    do_req(2'd0, 16'h4123, 8'h00, 9'h000, 1'b1, -1);
    do_req(2'd0, 16'h4123, 8'h00, 9'h000, 1'b0, -1);
    do_req(2'd3, 16'hA000, 8'h33, 9'h1A3, 1'b0, -1);
    do_req(2'd2, 16'h0777, 8'h00, 9'h1A3, 1'b0, -1);

    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0: a = 16'($urandom);
        1: a = 16'hA000 | 16'($urandom_range(0, 16'h1FFF));
        2: a = 16'h2000 | 16'($urandom_range(0, 16'h1FFF));
        default: a = 16'($urandom_range(0, 16'h7FFF));
      endcase
      do_req(2'($urandom_range(0, 3)), a, 8'($urandom), banks[$urandom_range(0, 2)],
             1'b0, -1);
    end

    idle_reset();
    do_req(2'd2, 16'h1234, 8'h00, 9'h005, 1'b0, -1);
    @(negedge clk);
    check("final_idle", 64'(obs(1'b0)),
          64'(mk(1, 0, m_last_addr, 1, 1, 1, 0, 0, 8'h00)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gb_bus_master.md
# gb_bus_master

Host-side GameBoy cartridge bus initiator. It turns single-beat requests from a cartridge dumper/flasher controller into timed cartridge bus cycles (phi, /RD, /WR, /CS, A15-A0, D7-D0). It also provides a banked-read operation that programs an MBC5-style ROM bank register before reading the switchable window. It sits between the host request logic and the cartridge connector pads.

## Interface
- PHASE_CLKS, 4, clk cycles per bus phase (≥1); one bus cycle = 4 phases T1..T4
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block idle, request accepted when valid&&ready at clk rising edge
- req_op  in  2  0=READ, 1=WRITE, 2=BANKED_READ, 3=reserved
- req_addr  in  16  bus address (BANKED_READ: only [13:0] used as window offset)
- req_wdata  in  8  write data
- req_bank  in  9  ROM bank for BANKED_READ
- rsp_valid  out  1  one-clock completion pulse
- rsp_rdata  out  8  read data (0xFF for WRITE/reserved)
- bus_addr  out  16  cartridge address
- bus_dout  out  8  cartridge write data
- bus_doe  out  1  data pad output enable
- bus_din  in  8  cartridge read data
- bus_phi  out  1  bus clock
- bus_rd_n, bus_wr_n, bus_cs_n  out  1 each  active-low strobes

## Operation
- States: IDLE, T1, T2, T3, T4; phase counter 0..PHASE_CLKS-1 advances the state on wrap.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0xFF, bus_addr=0x0000, bus_dout=0x00, bus_doe=0, bus_phi=0, bus_rd_n=bus_wr_n=bus_cs_n=1, bank_valid=0, bank_cache=0.
- Op expansion into a sequence of bus cycles:
  - READ: 1 read cycle at req_addr.
  - WRITE: 1 write cycle at req_addr.
  - BANKED_READ, cache miss: write req_bank[7:0] to 0x2000, write {7'b0,req_bank[8]} to 0x3000, then read 0x4000|req_addr[13:0].
  - BANKED_READ, cache hit (bank_valid && bank_cache==req_bank): read only.
  - Reserved: no bus cycle; rsp_valid on the clock after acceptance, rdata 0xFF.
- Request fields are latched at acceptance; later changes have no effect.
- Bank cache:
  - Set to req_bank, valid=1, when the 0x3000 write of a miss sequence completes.
  - A plain WRITE to 0x2000-0x3FFF clears bank_valid. Writes elsewhere leave it unchanged.
- Per-cycle strobes, all registered:
  - bus_addr valid from T1 through the following IDLE/T1.
  - bus_rd_n low T1-T4 for read cycles, high for write cycles.
  - bus_cs_n low T2-T4 when addr[15:13]==3'b101.
  - bus_phi high T3-T4.
  - Write cycles: bus_doe=1 and bus_dout valid T2-T4; bus_wr_n low during T3 only. The T3→T4 rising edge of /WR is the commit edge, and data stays stable through T4.
- Read data is sampled from bus_din at the clk edge ending the last T4 of the final read cycle.
- Consecutive cycles in one sequence: T4 goes directly to T1, with no idle gap.

## Timing
- Acceptance at edge k: req_ready drops in the following cycle and T1 begins at edge k.
- Sequence of N bus cycles: final T4 ends at edge k+4·PHASE_CLKS·N. In the cycle after that edge, rsp_valid=1, rsp_rdata holds its final value, and req_ready=1.
- A new request can be accepted in the same cycle as rsp_valid.
- rsp_rdata holds until the next completion.
- Read of A000-BFFF asserts both /RD and /CS.
- PHASE_CLKS=1 gives a 4-clock bus cycle.
- Reset during any state: all outputs return to reset values immediately. No rsp_valid is issued, the in-flight op is dropped, and bank_valid is cleared.
- req_valid held high while busy is ignored until req_ready returns.

## Test plan
- Reset: assert rst mid-idle -> all outputs at reset values; req_ready=1 after release.
- PHASE_CLKS=2, READ 0x0150, bus_din=0xCE -> rd_n low 8 clocks, cs_n/wr_n high, phi high last 4 clocks, rsp_valid 1 cycle at k+9 with rdata 0xCE.
- WRITE 0xA000 data 0x5A -> cs_n low T2-T4, doe high T2-T4 with dout 0x5A, wr_n low T3 only, rd_n high, rsp_rdata 0xFF.
- BANKED_READ bank 0x1A3 offset 0x0010 -> writes 0xA3@0x2000, 0x01@0x3000, read @0x4010 (3 cycles). Repeat same bank -> 1 cycle. WRITE 0x2100 then repeat -> 3 cycles again.
- Reset asserted during T3 of the 0x3000 write -> wr_n high immediately, no rsp_valid. Next BANKED_READ of same bank issues all 3 cycles.
- req_valid held high across two READs -> second accepted only in the rsp_valid cycle; reserved op -> rsp_valid at k+1, rdata 0xFF, no strobes.
